// File: rtl/enc_position_ctrl.sv
// Quadrature encoder position tracker: synchronizes encoder, button and switch
// inputs, decodes full detents into +/-1 steps and offers the position over a valid/ready handshake.
module enc_position_ctrl #(
  parameter int WIDTH   = 5,
  parameter int MAX_POS = 31,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             btn_in,
  input  logic             sw_in,
  output logic [WIDTH-1:0] pos_out,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [1:0]       dir,
  output logic             disp_en,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3, S_RESYNC
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_POS);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [1:0]       ab_meta_q, ab_meta_d, ab_q, ab_d;
  logic             btn_meta_q, btn_meta_d, btn_q, btn_d, btn_prev_q, btn_prev_d;
  logic             sw_meta_q, sw_meta_d, sw_q, sw_d;
  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pos_q, pos_d, pos_out_q, pos_out_d;
  logic [1:0]       dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             step_up, step_dn, illegal, btn_rise;

  always_comb begin
    ab_meta_d  = {a_in, b_in};
    ab_d       = ab_meta_q;
    btn_meta_d = btn_in;
    btn_d      = btn_meta_q;
    btn_prev_d = btn_q;
    sw_meta_d  = sw_in;
    sw_d       = sw_meta_q;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    // Each state accepts its own code (hold), the next code (advance) or the
    // previous code (back-step); the only remaining code is illegal.
    case (state_q)
      S_IDLE:   case (ab_q)
                  2'b01:   state_d = S_CW1;
                  2'b10:   state_d = S_CCW1;
                  2'b00:   illegal = 1'b1;
                  default: ;
                endcase
      S_CW1:    case (ab_q)
                  2'b11:   state_d = S_IDLE;
                  2'b00:   state_d = S_CW2;
                  2'b10:   illegal = 1'b1;
                  default: ;
                endcase
      S_CW2:    case (ab_q)
                  2'b01:   state_d = S_CW1;
                  2'b10:   state_d = S_CW3;
                  2'b11:   illegal = 1'b1;
                  default: ;
                endcase
      S_CW3:    case (ab_q)
                  2'b00:   state_d = S_CW2;
                  2'b11:   begin state_d = S_IDLE; step_up = 1'b1; end
                  2'b01:   illegal = 1'b1;
                  default: ;
                endcase
      S_CCW1:   case (ab_q)
                  2'b11:   state_d = S_IDLE;
                  2'b00:   state_d = S_CCW2;
                  2'b01:   illegal = 1'b1;
                  default: ;
                endcase
      S_CCW2:   case (ab_q)
                  2'b10:   state_d = S_CCW1;
                  2'b01:   state_d = S_CCW3;
                  2'b11:   illegal = 1'b1;
                  default: ;
                endcase
      S_CCW3:   case (ab_q)
                  2'b00:   state_d = S_CCW2;
                  2'b11:   begin state_d = S_IDLE; step_dn = 1'b1; end
                  2'b10:   illegal = 1'b1;
                  default: ;
                endcase
      S_RESYNC: if (ab_q == 2'b11) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (illegal) state_d = S_RESYNC;
    err_d = illegal;
  end

  assign btn_rise = btn_q & ~btn_prev_q;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (btn_rise) begin
      pos_d = '0;
      dir_d = 2'b00;
    end else if (step_up) begin
      dir_d = 2'b01;
      if (pos_q == MAX_V) pos_d = (WRAP != 0) ? '0 : MAX_V;
      else                pos_d = pos_q + ONE_V;
    end else if (step_dn) begin
      dir_d = 2'b10;
      if (pos_q == '0) pos_d = (WRAP != 0) ? MAX_V : '0;
      else             pos_d = pos_q - ONE_V;
    end
  end

  // A pending value is held until taken; a fresh load only happens from the idle side.
  always_comb begin
    valid_d   = valid_q;
    pos_out_d = pos_out_q;
    if (valid_q) begin
      if (upd_ready) valid_d = 1'b0;
    end else if (sw_q && (pos_q != pos_out_q)) begin
      valid_d   = 1'b1;
      pos_out_d = pos_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_meta_q  <= 2'b11;
      ab_q       <= 2'b11;
      btn_meta_q <= 1'b0;
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_q       <= 1'b0;
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      pos_q      <= '0;
      dir_q      <= 2'b00;
      pos_out_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      ab_meta_q  <= ab_meta_d;
      ab_q       <= ab_d;
      btn_meta_q <= btn_meta_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      sw_meta_q  <= sw_meta_d;
      sw_q       <= sw_d;
      state_q    <= state_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      pos_out_q  <= pos_out_d;
      valid_q    <= valid_d;
    end
  end

  assign pos_out   = pos_out_q;
  assign upd_valid = valid_q;
  assign dir       = dir_q;
  assign disp_en   = sw_q;
  assign err       = err_q;

endmodule

// File: tb/tb_enc_position_ctrl.sv
// Bench for enc_position_ctrl: a wrapping and a saturating instance driven by the same stimulus,
// checked every cycle against a detent-offset reference model, plus directed scenario checks.
module tb_enc_position_ctrl;

  localparam int WIDTH   = 5;
  localparam int MAX_POS = 20;

  logic clk = 1'b0;
  logic rst_n, a_in, b_in, btn_in, sw_in, upd_ready;
  logic [WIDTH-1:0] pos_w, pos_s;
  logic valid_w, valid_s, en_w, en_s, err_w, err_s;
  logic [1:0] dir_w, dir_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  enc_position_ctrl #(.WIDTH(WIDTH), .MAX_POS(MAX_POS), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .btn_in(btn_in), .sw_in(sw_in),
    .pos_out(pos_w), .upd_valid(valid_w), .upd_ready(upd_ready), .dir(dir_w),
    .disp_en(en_w), .err(err_w));

  enc_position_ctrl #(.WIDTH(WIDTH), .MAX_POS(MAX_POS), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .btn_in(btn_in), .sw_in(sw_in),
    .pos_out(pos_s), .upd_valid(valid_s), .upd_ready(upd_ready), .dir(dir_s),
    .disp_en(en_s), .err(err_s));

  // Reference model: the decoder is an offset along the Gray cycle 11,01,00,10;
  // four net steps in one direction make a detent, a jump of two codes is illegal.
  int m_ab1, m_ab2, m_last, m_off;
  bit m_btn1, m_btn2, m_btnp, m_sw1, m_sw2, m_resync, m_err;
  int m_pos[2], m_dir[2], m_pout[2];
  bit m_val[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gidx(input int code);
    case (code)
      3: return 0;
      1: return 1;
      0: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int move(input int p, input int s, input bit wrap);
    int n;
    if (wrap) return (p + s + MAX_POS + 1) % (MAX_POS + 1);
    n = p + s;
    if (n < 0) n = 0;
    if (n > MAX_POS) n = MAX_POS;
    return n;
  endfunction

  task automatic model_reset();
    m_ab1 = 3; m_ab2 = 3; m_last = 3; m_off = 0;
    m_btn1 = 0; m_btn2 = 0; m_btnp = 0; m_sw1 = 0; m_sw2 = 0;
    m_resync = 0; m_err = 0;
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_dir[k] = 0; m_pout[k] = 0; m_val[k] = 0;
    end
  endtask

  task automatic model_edge();
    int d, step;
    bit e, rise;
    step = 0;
    e = 0;
    d = (gidx(m_ab2) - gidx(m_last)) & 3;
    if (m_resync) begin
      if (m_ab2 == 3) begin m_resync = 0; m_off = 0; end
    end else if (d == 2) begin
      e = 1; m_resync = 1;
    end else if (d == 1) begin
      m_off++;
      if (m_off == 4) begin m_off = 0; step = 1; end
    end else if (d == 3) begin
      m_off--;
      if (m_off == -4) begin m_off = 0; step = -1; end
    end
    m_last = m_ab2;
    rise = m_btn2 && !m_btnp;
    for (int k = 0; k < 2; k++) begin
      if (m_val[k]) begin
        if (upd_ready) m_val[k] = 0;
      end else if (m_sw2 && (m_pos[k] != m_pout[k])) begin
        m_val[k] = 1; m_pout[k] = m_pos[k];
      end
      if (rise) begin
        m_pos[k] = 0; m_dir[k] = 0;
      end else if (step != 0) begin
        m_dir[k] = (step > 0) ? 1 : 2;
        m_pos[k] = move(m_pos[k], step, (k == 0));
      end
    end
    m_err = e;
    m_btnp = m_btn2; m_btn2 = m_btn1; m_btn1 = btn_in;
    m_sw2 = m_sw1;   m_sw1 = sw_in;
    m_ab2 = m_ab1;   m_ab1 = {30'd0, a_in, b_in};
  endtask

  task automatic compare_all();
    check("wrap.pos_out", 32'(pos_w), 32'(m_pout[0]));
    check("wrap.upd_valid", 32'(valid_w), 32'(m_val[0]));
    check("wrap.dir", 32'(dir_w), 32'(m_dir[0]));
    check("sat.pos_out", 32'(pos_s), 32'(m_pout[1]));
    check("sat.upd_valid", 32'(valid_s), 32'(m_val[1]));
    check("sat.dir", 32'(dir_s), 32'(m_dir[1]));
    check("err", 32'({err_w, err_s}), m_err ? 32'd3 : 32'd0);
    check("disp_en", 32'({en_w, en_s}), m_sw2 ? 32'd3 : 32'd0);
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else        model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_ab(input logic [1:0] code, input int hold);
    {a_in, b_in} = code;
    repeat (hold) tick();
  endtask

  task automatic detent_cw();
    set_ab(2'b01, 3); set_ab(2'b00, 3); set_ab(2'b10, 3); set_ab(2'b11, 6);
  endtask

  task automatic detent_ccw();
    set_ab(2'b10, 3); set_ab(2'b00, 3); set_ab(2'b01, 3); set_ab(2'b11, 6);
  endtask

  task automatic clear_pos();
    btn_in = 1'b1;
    repeat (4) tick();
    btn_in = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int r;
    rst_n = 1'b0; a_in = 1'b1; b_in = 1'b1; btn_in = 1'b0; sw_in = 1'b0; upd_ready = 1'b0;
    model_reset();
    #2;
    repeat (3) tick();
    check("rst.pos_out", 32'(pos_w), 32'd0);
    check("rst.upd_valid", 32'(valid_w), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // One CW detent with the display enabled: valid 4 clocks after the final 11, for one cycle.
    sw_in = 1'b1; upd_ready = 1'b1;
    repeat (3) tick();
    set_ab(2'b01, 3); set_ab(2'b00, 3); set_ab(2'b10, 3);
    set_ab(2'b11, 3);
    check("cw.valid_early", 32'(valid_w), 32'd0);
    tick();
    check("cw.valid", 32'(valid_w), 32'd1);
    check("cw.pos_out", 32'(pos_w), 32'd1);
    check("cw.dir", 32'(dir_w), 32'd1);
    tick();
    check("cw.valid_drop", 32'(valid_w), 32'd0);

    // Two CCW detents from 0: wrap goes to MAX_POS then MAX_POS-1, saturate stays at 0.
    clear_pos();
    detent_ccw();
    check("ccw1.wrap", 32'(pos_w), 32'(MAX_POS));
    check("ccw1.sat", 32'(pos_s), 32'd0);
    detent_ccw();
    check("ccw2.wrap", 32'(pos_w), 32'(MAX_POS - 1));
    check("ccw2.sat_dir", 32'(dir_s), 32'd2);

    // Back-pressure: three CW detents while the consumer stalls.
    clear_pos();
    upd_ready = 1'b0;
    repeat (3) detent_cw();
    check("bp.pos_out", 32'(pos_w), 32'd1);
    check("bp.valid", 32'(valid_w), 32'd1);
    upd_ready = 1'b1;
    tick();
    check("bp.drop", 32'(valid_w), 32'd0);
    tick();
    check("bp.revalid", 32'(valid_w), 32'd1);
    check("bp.pos3", 32'(pos_w), 32'd3);
    repeat (2) tick();

    // Illegal 11->00 jump, recovery through 11, then a legal CW detent.
    clear_pos();
    set_ab(2'b00, 2);
    tick();
    check("ill.err", 32'(err_w), 32'd1);
    tick();
    check("ill.err_pulse", 32'(err_w), 32'd0);
    set_ab(2'b00, 2);
    set_ab(2'b11, 6);
    check("ill.nostep", 32'(pos_w), 32'd0);
    detent_cw();
    check("ill.recover", 32'(pos_w), 32'd1);

    // Button edge in the same cycle as the CW3->IDLE step at position 5.
    clear_pos();
    repeat (5) detent_cw();
    check("btn.pos5", 32'(pos_w), 32'd5);
    set_ab(2'b01, 3); set_ab(2'b00, 3); set_ab(2'b10, 3);
    btn_in = 1'b1;
    set_ab(2'b11, 6);
    check("btn.pos_out", 32'(pos_w), 32'd0);
    check("btn.dir", 32'(dir_w), 32'd0);
    btn_in = 1'b0;
    repeat (4) tick();

    // Reset during CW2 with a pending valid.
    upd_ready = 1'b0;
    detent_cw();
    set_ab(2'b01, 3); set_ab(2'b00, 3);
    check("rst2.pending", 32'(valid_w), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2.pos_out", 32'({pos_w, pos_s}), 32'd0);
    check("rst2.valid", 32'({valid_w, valid_s}), 32'd0);
    check("rst2.dir_err_en", 32'({dir_w, err_w, en_w}), 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    set_ab(2'b00, 3); set_ab(2'b10, 3); set_ab(2'b11, 8);
    check("rst2.nostep", 32'(pos_w), 32'd0);
    check("rst2.novalid", 32'(valid_w), 32'd0);

    // Randomized walk; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        if ($urandom_range(0, 1) == 0) a_in = ~a_in;
        else                           b_in = ~b_in;
      end else if (r < 74) begin
        a_in = ~a_in; b_in = ~b_in;
      end else if (r < 82) begin
        btn_in = ~btn_in;
      end else if (r < 87) begin
        sw_in = ~sw_in;
      end
      upd_ready = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 4)) tick();
    end
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
